ycbcr444_2_yuv422: RTL and testbench
====================================

YCBCR444_2_YUV422 -- requirements
Module: ycbcr444_2_yuv422

Interface
REQ-001 SHALL have one clock and one reset: the clock is single, and the reset is asynchronous and active-high.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 i_v_sync  input  1  frame sync, passed through with pipeline delay.
REQ-005 i_h_sync  input  1  line sync, passed through with pipeline delay.
REQ-006 i_de  input  1  active-pixel enable; one 4:4:4 pixel per high cycle.
REQ-007 y_in  input  8  luma.
REQ-008 cb_in  input  8  blue-difference chroma.
REQ-009 cr_in  input  8  red-difference chroma.
REQ-010 o_v_sync  output  1  i_v_sync delayed 2 cycles.
REQ-011 o_h_sync  output  1  i_h_sync delayed 2 cycles.
REQ-012 o_de  output  1  i_de delayed 2 cycles.
REQ-013 y_out  output  8  luma of the output pixel.
REQ-014 c_out  output  8  multiplexed chroma: Cb on even pixels, Cr on odd pixels, giving Cb0Y0, Cr0Y1, Cb1Y2, ... on {c_out,y_out}.

Function
REQ-015 Pixel phase SHALL reset to even (0) on every cycle with i_de low, and SHALL toggle on every i_de-high cycle, so the first pixel of each line is even.
REQ-016 Latency SHALL be exactly 2 clocks for every pixel, for all sync and data outputs, with and without CHROMA_AVG_EN.
REQ-017 Even pixel P2k SHALL be output as y_out=Y(2k), c_out=Cb_pair.
REQ-018 Odd pixel P2k+1 SHALL be output as y_out=Y(2k+1), c_out=Cr_pair.
REQ-019 Cb_pair and Cr_pair SHALL be computed once per pair, in the cycle the odd pixel is registered, and Cr_pair SHALL be held 1 cycle for the odd-slot output.
REQ-020 Averaging SHALL be (a+b+1)>>1, using a 9-bit intermediate sum; the result SHALL never overflow 8 bits.
REQ-021 Odd-length line: when an even pixel is followed by i_de low, Cb_pair SHALL equal that pixel's own Cb, and no Cr slot SHALL be emitted.
REQ-022 When o_de is low, y_out and c_out SHALL be 0.
REQ-023 A 1-cycle i_de gap SHALL restart phase at even on the next high cycle, with no chroma carried across the gap.
REQ-024 Sync inputs SHALL only be delayed, never qualified or regenerated.

Reset
REQ-025 While rst is high, all outputs SHALL be 0, phase SHALL be even, and the delay lines and chroma holding registers SHALL be 0.
REQ-026 Reset asserted mid-line SHALL discard the partial pair; after rst deasserts, the first i_de-high cycle SHALL be treated as even.

Configuration
REQ-027 Macro YCBCR422_CHROMA_AVG_EN defined: Cb_pair=avg(Cb2k,Cb2k+1) and Cr_pair=avg(Cr2k,Cr2k+1), rounded per REQ-020.
REQ-028 Macro undefined: co-sited decimation, with Cb_pair=Cb2k and Cr_pair=Cr2k; odd-pixel chroma is ignored; latency is unchanged.

Structure
REQ-029 Shared package ycbcr_pkg SHALL hold PIX_W=8, YCBCR422_LAT=2 and the phase enumeration (PH_EVEN, PH_ODD); the sibling 4:2:2-to-4:4:4 converter SHALL reuse it.
REQ-030 The rounded two-input average SHALL be sub-module chroma_avg2 (combinational, width PIX_W), instantiated twice (Cb, Cr) only when YCBCR422_CHROMA_AVG_EN is defined.

Verification
REQ-031 4-pixel line (Y,Cb,Cr)=(10,100,200),(20,110,210),(30,50,60),(40,51,61), AVG_EN -> from 2 cycles after the first pixel, {c_out,y_out}=(105,10),(205,20),(51,30),(61,40).
REQ-032 Same stimulus without macro -> (100,10),(200,20),(50,30),(60,40).
REQ-033 Rounding/overflow, AVG_EN: pair Cb=255,254 and Cr=0,1 -> c_out=255 then 1.
REQ-034 3-pixel line then i_de low -> third output c_out=its own Cb, and o_de falls 2 cycles after i_de; a 1-cycle gap followed by a new line -> first new pixel output on a Cb slot.
REQ-035 rst pulsed mid-pair, then a new line -> outputs 0 during rst, and the first post-reset pixel is emitted as an even (Cb) pixel.
REQ-036 Toggle i_v_sync and i_h_sync arbitrarily -> o_v_sync and o_h_sync match them exactly, delayed 2 cycles.

Source files
------------

// File: rtl/ycbcr_pkg.sv
// Shared definitions for the 4:4:4 <-> 4:2:2 YCbCr converters.
package ycbcr_pkg;
  localparam int unsigned PIX_W        = 8;
  localparam int unsigned YCBCR422_LAT = 2;

  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_e;

  typedef struct packed {
    logic [PIX_W-1:0] y;
    logic [PIX_W-1:0] cb;
    logic [PIX_W-1:0] cr;
  } pix444_t;
endpackage

// File: rtl/chroma_avg2.sv
// Rounded two-input average (a+b+1)>>1; the extra sum bit keeps the result in range.
module chroma_avg2
  import ycbcr_pkg::*;
#(
  parameter int unsigned W = PIX_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] avg_c
);
  logic [W:0] sum;

  assign sum   = (W+1)'(a) + (W+1)'(b) + (W+1)'(1);
  assign avg_c = sum[W:1];
endmodule

// File: rtl/ycbcr444_2_yuv422.sv
// 4:4:4 to 4:2:2 chroma decimation with a fixed 2-cycle latency.
// YCBCR422_CHROMA_AVG_EN selects pair averaging; otherwise chroma is co-sited on the even pixel.
module ycbcr444_2_yuv422
  import ycbcr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_v_sync,
  input  logic             i_h_sync,
  input  logic             i_de,
  input  logic [PIX_W-1:0] y_in,
  input  logic [PIX_W-1:0] cb_in,
  input  logic [PIX_W-1:0] cr_in,
  output logic             o_v_sync,
  output logic             o_h_sync,
  output logic             o_de,
  output logic [PIX_W-1:0] y_out,
  output logic [PIX_W-1:0] c_out
);
  phase_e           phase, phase_next;
  phase_e           s1_phase;
  logic             s1_de, s1_v, s1_h;
  pix444_t          s1_pix;
  logic [PIX_W-1:0] cr_hold;
  logic [PIX_W-1:0] cb_pair, cr_pair;

  // Phase register: even on idle cycles, toggles per active pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase <= PH_EVEN;
    else     phase <= phase_next;
  end

  always_comb begin
    phase_next = PH_EVEN;
    if (i_de) phase_next = (phase == PH_EVEN) ? PH_ODD : PH_EVEN;
  end

`ifdef YCBCR422_CHROMA_AVG_EN
  logic             pair_valid;
  logic [PIX_W-1:0] cb_avg, cr_avg;

  // An even pixel in stage 1 pairs with the odd pixel currently at the input.
  assign pair_valid = s1_de && (s1_phase == PH_EVEN) && i_de;

  chroma_avg2 #(.W(PIX_W)) u_cb_avg (.a(s1_pix.cb), .b(cb_in), .avg_c(cb_avg));
  chroma_avg2 #(.W(PIX_W)) u_cr_avg (.a(s1_pix.cr), .b(cr_in), .avg_c(cr_avg));

  assign cb_pair = pair_valid ? cb_avg : s1_pix.cb;
  assign cr_pair = pair_valid ? cr_avg : s1_pix.cr;
`else
  assign cb_pair = s1_pix.cb;
  assign cr_pair = s1_pix.cr;
`endif

  // Stage 1 capture, then output stage with Cr held for the odd slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_phase <= PH_EVEN;
      s1_de    <= 1'b0;
      s1_v     <= 1'b0;
      s1_h     <= 1'b0;
      s1_pix   <= '0;
      cr_hold  <= '0;
      o_de     <= 1'b0;
      o_v_sync <= 1'b0;
      o_h_sync <= 1'b0;
      y_out    <= '0;
      c_out    <= '0;
    end else begin
      s1_phase <= phase;
      s1_de    <= i_de;
      s1_v     <= i_v_sync;
      s1_h     <= i_h_sync;
      s1_pix   <= '{y: y_in, cb: cb_in, cr: cr_in};
      o_de     <= s1_de;
      o_v_sync <= s1_v;
      o_h_sync <= s1_h;
      y_out    <= s1_de ? s1_pix.y : '0;
      c_out    <= '0;
      if (s1_de) c_out <= (s1_phase == PH_EVEN) ? cb_pair : cr_hold;
      if (s1_de && (s1_phase == PH_EVEN)) cr_hold <= cr_pair;
    end
  end
endmodule

// File: tb/tb_ycbcr444_2_yuv422.sv
// Directed bench for ycbcr444_2_yuv422; expectations follow YCBCR422_CHROMA_AVG_EN.
module tb_ycbcr444_2_yuv422;
  logic       clk = 1'b0;
  logic       rst;
  logic       i_v_sync, i_h_sync, i_de;
  logic [7:0] y_in, cb_in, cr_in;
  logic       o_v_sync, o_h_sync, o_de;
  logic [7:0] y_out, c_out;

  int errors = 0;
  int checks = 0;

  ycbcr444_2_yuv422 dut (
    .clk(clk), .rst(rst),
    .i_v_sync(i_v_sync), .i_h_sync(i_h_sync), .i_de(i_de),
    .y_in(y_in), .cb_in(cb_in), .cr_in(cr_in),
    .o_v_sync(o_v_sync), .o_h_sync(o_h_sync), .o_de(o_de),
    .y_out(y_out), .c_out(c_out)
  );

  always #5 clk = ~clk;

  task automatic step(input logic de, input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
    i_de = de; y_in = y; cb_in = cb; cr_in = cr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_v_sync = 1'b1; i_h_sync = 1'b1;
    step(1'b1, 8'd9, 8'd9, 8'd9);
    step(1'b1, 8'd7, 8'd7, 8'd7);
    checks++;
    if ({o_v_sync, o_h_sync, o_de, c_out, y_out} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b h=%0b de=%0b c=%0d y=%0d, want all 0",
               o_v_sync, o_h_sync, o_de, c_out, y_out);
    end
    rst = 1'b0; i_v_sync = 1'b0; i_h_sync = 1'b0;
    step(1'b0, 8'd0, 8'd0, 8'd0);
    step(1'b0, 8'd0, 8'd0, 8'd0);
    checks++;
    if ({o_v_sync, o_h_sync, o_de, c_out, y_out} !== 19'd0) begin
      errors++;
      $display("FAIL reset_idle: got v=%0b h=%0b de=%0b c=%0d y=%0d, want all 0",
               o_v_sync, o_h_sync, o_de, c_out, y_out);
    end
  endtask

  task automatic test_line4();
    logic       ide [6] = '{1, 1, 1, 1, 0, 0};
    logic [7:0] iy  [6] = '{10, 20, 30, 40, 0, 0};
    logic [7:0] icb [6] = '{100, 110, 50, 51, 0, 0};
    logic [7:0] icr [6] = '{200, 210, 60, 61, 0, 0};
    logic       ede [6] = '{0, 1, 1, 1, 1, 0};
    logic [7:0] ey  [6] = '{0, 10, 20, 30, 40, 0};
`ifdef YCBCR422_CHROMA_AVG_EN
    logic [7:0] ec  [6] = '{0, 105, 205, 51, 61, 0};
`else
    logic [7:0] ec  [6] = '{0, 100, 200, 50, 60, 0};
`endif
    for (int k = 0; k < 6; k++) begin
      step(ide[k], iy[k], icb[k], icr[k]);
      checks++;
      if ({o_de, c_out, y_out} !== {ede[k], ec[k], ey[k]}) begin
        errors++;
        $display("FAIL line4[%0d]: got de=%0b c=%0d y=%0d, want de=%0b c=%0d y=%0d",
                 k, o_de, c_out, y_out, ede[k], ec[k], ey[k]);
      end
    end
  endtask

  task automatic test_rounding();
    logic       ide [4] = '{1, 1, 0, 0};
    logic [7:0] iy  [4] = '{1, 2, 0, 0};
    logic [7:0] icb [4] = '{255, 254, 0, 0};
    logic [7:0] icr [4] = '{0, 1, 0, 0};
    logic       ede [4] = '{0, 1, 1, 0};
    logic [7:0] ey  [4] = '{0, 1, 2, 0};
`ifdef YCBCR422_CHROMA_AVG_EN
    logic [7:0] ec  [4] = '{0, 255, 1, 0};
`else
    logic [7:0] ec  [4] = '{0, 255, 0, 0};
`endif
    for (int k = 0; k < 4; k++) begin
      step(ide[k], iy[k], icb[k], icr[k]);
      checks++;
      if ({o_de, c_out, y_out} !== {ede[k], ec[k], ey[k]}) begin
        errors++;
        $display("FAIL rounding[%0d]: got de=%0b c=%0d y=%0d, want de=%0b c=%0d y=%0d",
                 k, o_de, c_out, y_out, ede[k], ec[k], ey[k]);
      end
    end
  endtask

  // Odd-length line, one idle cycle, then a fresh line starting on a Cb slot.
  task automatic test_odd_line_gap();
    logic       ide [8] = '{1, 1, 1, 0, 1, 1, 0, 0};
    logic [7:0] iy  [8] = '{11, 12, 13, 0, 14, 15, 0, 0};
    logic [7:0] icb [8] = '{80, 81, 70, 0, 40, 42, 0, 0};
    logic [7:0] icr [8] = '{90, 91, 120, 0, 140, 142, 0, 0};
    logic       ede [8] = '{0, 1, 1, 1, 0, 1, 1, 0};
    logic [7:0] ey  [8] = '{0, 11, 12, 13, 0, 14, 15, 0};
`ifdef YCBCR422_CHROMA_AVG_EN
    logic [7:0] ec  [8] = '{0, 81, 91, 70, 0, 41, 141, 0};
`else
    logic [7:0] ec  [8] = '{0, 80, 90, 70, 0, 40, 140, 0};
`endif
    for (int k = 0; k < 8; k++) begin
      step(ide[k], iy[k], icb[k], icr[k]);
      checks++;
      if ({o_de, c_out, y_out} !== {ede[k], ec[k], ey[k]}) begin
        errors++;
        $display("FAIL odd_gap[%0d]: got de=%0b c=%0d y=%0d, want de=%0b c=%0d y=%0d",
                 k, o_de, c_out, y_out, ede[k], ec[k], ey[k]);
      end
    end
  endtask

  task automatic test_reset_mid_pair();
    logic [7:0] ey [4] = '{0, 60, 61, 0};
    logic       ede [4] = '{0, 1, 1, 0};
`ifdef YCBCR422_CHROMA_AVG_EN
    logic [7:0] ec [4] = '{0, 71, 81, 0};
`else
    logic [7:0] ec [4] = '{0, 70, 80, 0};
`endif
    step(1'b1, 8'd50, 8'd20, 8'd30);
    rst = 1'b1;
    i_de = 1'b1; y_in = 8'd51; cb_in = 8'd22; cr_in = 8'd33;
    #1;
    checks++;
    if ({o_de, c_out, y_out} !== 17'd0) begin
      errors++;
      $display("FAIL rst_async: got de=%0b c=%0d y=%0d, want 0", o_de, c_out, y_out);
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 8'd52, 8'd23, 8'd34);
      checks++;
      if ({o_de, c_out, y_out} !== 17'd0) begin
        errors++;
        $display("FAIL rst_held[%0d]: got de=%0b c=%0d y=%0d, want 0", k, o_de, c_out, y_out);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0:       step(1'b1, 8'd60, 8'd70, 8'd80);
        1:       step(1'b1, 8'd61, 8'd72, 8'd82);
        default: step(1'b0, 8'd0, 8'd0, 8'd0);
      endcase
      checks++;
      if ({o_de, c_out, y_out} !== {ede[k], ec[k], ey[k]}) begin
        errors++;
        $display("FAIL post_rst[%0d]: got de=%0b c=%0d y=%0d, want de=%0b c=%0d y=%0d",
                 k, o_de, c_out, y_out, ede[k], ec[k], ey[k]);
      end
    end
  endtask

  task automatic test_sync();
    logic [15:0] vpat = 16'b1011_0010_1110_0101;
    logic [15:0] hpat = 16'b0110_1100_0101_1001;
    for (int k = 0; k < 16; k++) begin
      i_v_sync = vpat[k];
      i_h_sync = hpat[k];
      step(k[0], 8'd0, 8'd0, 8'd0);
      if (k >= 1) begin
        checks++;
        if ({o_v_sync, o_h_sync} !== {vpat[k-1], hpat[k-1]}) begin
          errors++;
          $display("FAIL sync[%0d]: got v=%0b h=%0b, want v=%0b h=%0b",
                   k, o_v_sync, o_h_sync, vpat[k-1], hpat[k-1]);
        end
      end
    end
    i_v_sync = 1'b0; i_h_sync = 1'b0;
    step(1'b0, 8'd0, 8'd0, 8'd0);
    step(1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  initial begin
    rst = 1'b1; i_v_sync = 1'b0; i_h_sync = 1'b0;
    i_de = 1'b0; y_in = '0; cb_in = '0; cr_in = '0;
    test_reset();
    test_line4();
    test_rounding();
    test_odd_line_gap();
    test_reset_mid_pair();
    test_sync();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
